// File: rtl/uart_rx_pkg.sv
// Shared types and configuration helpers for the UART receive controller.
package uart_rx_pkg;

    // Gray-coded along the normal frame path IDLE->START->DATA->PARITY->STOP->DONE
    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        START    = 3'b001,
        DATA     = 3'b011,
        PARITY   = 3'b010,
        STOP     = 3'b110,
        DONE     = 3'b111,
        BRK_WAIT = 3'b101
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam int   CNT_W    = 6;

    function automatic int unsigned eff_prescale(input int unsigned pr);
        return (pr == 32'd8 || pr == 32'd16 || pr == 32'd32) ? pr : 32'd16;
    endfunction

    function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_w);
        return (len >= 32'd5 && len <= max_w) ? len : max_w;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             run,
    input  logic [CNT_W-1:0] prsc,
    input  logic             rx,
    output logic             bit_val,
    output logic             decide,
    output logic             wrap
);

    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] half;
    logic [2:0]       smp;

    assign half    = prsc >> 1;
    assign wrap    = run && (edge_cnt == prsc - CNT_W'(1));
    assign decide  = run && (edge_cnt == half + CNT_W'(2));
    assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            smp      <= '0;
        end else begin
            // the start-detect cycle itself is edge 0, so the first START cycle is edge 1
            if (start)
                edge_cnt <= CNT_W'(1);
            else if (!run || wrap)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + CNT_W'(1);

            if (run && edge_cnt == half - CNT_W'(1)) smp[0] <= rx;
            if (run && edge_cnt == half)             smp[1] <= rx;
            if (run && edge_cnt == half + CNT_W'(1)) smp[2] <= rx;
        end
    end

endmodule

// File: rtl/uart_rx_fsm_gen.sv
// UART receive controller: frame FSM, bit counter, deserializer,
// parity/stop/break checks on top of the majority-vote sampler.
module uart_rx_fsm_gen
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int PRSC_W = 6
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [PRSC_W-1:0] Prescale,
    input  logic [3:0]        DATA_LEN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              brk_det
);

    rx_state_e         state;
    logic [CNT_W-1:0]  p_l;
    logic [3:0]        len_l, bit_cnt, stop1_bit, last_bit;
    logic              par_en_l, par_typ_l, stop2_l;
    logic [DATA_W-1:0] shreg;
    logic              all_zero;
    logic              start, run, bit_val, decide, wrap;
    logic              exp_par, brk_now, good_now;

    assign start     = (state == IDLE) && !RX_IN;
    assign run       = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    assign stop1_bit = len_l + 4'd1 + {3'b000, par_en_l};
    assign last_bit  = stop1_bit + {3'b000, stop2_l};
    assign exp_par   = (par_typ_l == PAR_ODD) ? ~^shreg : ^shreg;
    // all_zero already covers the first stop bit when two stops are used
    assign brk_now   = all_zero && (stop2_l || !bit_val);
    assign good_now  = !par_err && !stp_err && bit_val;

    uart_rx_sampler u_smp (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .run     (run),
        .prsc    (p_l),
        .rx      (RX_IN),
        .bit_val (bit_val),
        .decide  (decide),
        .wrap    (wrap)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            p_l        <= CNT_W'(16);
            len_l      <= 4'(DATA_W);
            par_en_l   <= 1'b0;
            par_typ_l  <= PAR_EVEN;
            stop2_l    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            all_zero   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            brk_det    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            brk_det    <= 1'b0;
            if (wrap) bit_cnt <= bit_cnt + 4'd1;

            case (state)
                IDLE: if (!RX_IN) begin
                    state     <= START;
                    p_l       <= CNT_W'(eff_prescale(32'(Prescale)));
                    len_l     <= 4'(eff_len(32'(DATA_LEN), 32'(DATA_W)));
                    par_en_l  <= PAR_EN;
                    par_typ_l <= PAR_TYP;
                    stop2_l   <= STOP2;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    all_zero  <= 1'b1;
                    par_err   <= 1'b0;
                    stp_err   <= 1'b0;
                end
                START: begin
                    if (decide && bit_val) state <= IDLE;
                    else if (wrap)         state <= DATA;
                end
                DATA: begin
                    if (decide) begin
                        shreg[bit_cnt - 4'd1] <= bit_val;
                        all_zero              <= all_zero & ~bit_val;
                    end
                    if (wrap && bit_cnt == len_l) state <= par_en_l ? PARITY : STOP;
                end
                PARITY: begin
                    if (decide) begin
                        if (bit_val != exp_par) par_err <= 1'b1;
                        all_zero <= all_zero & ~bit_val;
                    end
                    if (wrap) state <= STOP;
                end
                STOP: if (decide) begin
                    if (!bit_val) stp_err <= 1'b1;
                    if (bit_cnt == last_bit) begin
                        state <= DONE;
                        if (brk_now) begin
                            brk_det <= 1'b1;
                        end else if (good_now) begin
                            data_valid <= 1'b1;
                            P_DATA     <= shreg;
                        end
                    end else begin
                        all_zero <= all_zero & ~bit_val;
                    end
                end
                DONE:     state <= brk_det ? BRK_WAIT : IDLE;
                BRK_WAIT: if (RX_IN) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm_gen.sv
// Directed-frame bench: stimulus queues expected output events, a monitor checks them.
module tb_uart_rx_fsm_gen;

    logic       CLK, RST, RX_IN;
    logic [5:0] Prescale;
    logic [3:0] DATA_LEN;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic [8:0] P_DATA;
    logic       data_valid, par_err, stp_err, brk_det;

    typedef struct {
        bit         brk;
        logic [8:0] data;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;

    uart_rx_fsm_gen dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .DATA_LEN   (DATA_LEN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .brk_det    (brk_det)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge CLK) begin
        if (RST && (data_valid || brk_det)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, brk_det, data_valid}, 32'd0);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("data_valid", data_valid, !mon_ev.brk);
                chk("brk_det", brk_det, mon_ev.brk);
                chk("event_cycle", cyc, mon_ev.cyc);
                if (!mon_ev.brk) chk("P_DATA", P_DATA, mon_ev.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // bit 0 = start, then data LSB first, optional parity, then stop bits
    function automatic logic [15:0] frame(input int len, input logic [8:0] d, input bit pe,
                                          input bit pb, input int nstop, input bit sv);
        logic [15:0] f;
        int k;
        f = '0;
        k = 1;
        for (int i = 0; i < len; i++) begin f[k] = d[i]; k++; end
        if (pe) begin f[k] = pb; k++; end
        for (int i = 0; i < nstop; i++) begin f[k] = sv; k++; end
        return f;
    endfunction

    // Drives n bits of P cycles each (last one last_len cycles); optional one-cycle
    // dip at mid-bit of bit dip_bit; optional check that flags cleared at start detect.
    task automatic send(input int p, input logic [15:0] bits, input int n, input int last_len,
                        input int dip_bit, input bit chk_clr);
        int len;
        for (int i = 0; i < n; i++) begin
            len = (i == n - 1) ? last_len : p;
            for (int j = 0; j < len; j++) begin
                RX_IN = (i == dip_bit && j == p / 2) ? ~bits[i] : bits[i];
                @(posedge CLK);
                #1;
                if (chk_clr && i == 0 && j == 0) begin
                    chk("par_err_clr_at_start", par_err, 1'b0);
                    chk("stp_err_clr_at_start", stp_err, 1'b0);
                end
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic cfg(input logic [5:0] p, input logic [3:0] l, input bit pe, input bit pt, input bit s2);
        Prescale = p;
        DATA_LEN = l;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST   = 1'b0;
        RX_IN = 1'b1;
        cfg(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("rst_P_DATA", P_DATA, 9'h000);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_par_err", par_err, 1'b0);
        chk("rst_stp_err", stp_err, 1'b0);
        chk("rst_brk_det", brk_det, 1'b0);
        RST = 1'b1;
        idle(3);

        // 8N1, P=8, 0xA5: 10 bits -> 9*8+4+2 = 78
        cfg(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{1'b0, 9'h0A5, cyc + 1 + 78});
        send(8, frame(8, 9'h0A5, 0, 0, 1, 1), 10, 8, -1, 0);
        idle(4);
        chk("a5_par_err", par_err, 1'b0);
        chk("a5_stp_err", stp_err, 1'b0);

        // 7E2, P=16, 0x3C with parity bit 1 (correct even parity is 0)
        cfg(6'd16, 4'd7, 1'b1, 1'b0, 1'b1);
        send(16, frame(7, 9'h03C, 1, 1, 2, 1), 11, 16, -1, 0);
        idle(4);
        chk("7e2_par_err", par_err, 1'b1);
        chk("7e2_stp_err", stp_err, 1'b0);
        chk("7e2_P_DATA_held", P_DATA, 9'h0A5);

        // 9O1, P=32, back-to-back 0x1FF / 0x001: 12 bits -> 11*32+16+2 = 370
        // last stop held P/2+4 cycles so the next start lands 1 cycle after DONE
        cfg(6'd32, 4'd9, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('{1'b0, 9'h1FF, cyc + 1 + 370});
        send(32, frame(9, 9'h1FF, 1, 0, 1, 1), 12, 20, -1, 1);
        exp_q.push_back('{1'b0, 9'h001, cyc + 1 + 370});
        send(32, frame(9, 9'h001, 1, 0, 1, 1), 12, 32, -1, 0);
        idle(4);
        chk("9o1_par_err", par_err, 1'b0);
        chk("9o1_stp_err", stp_err, 1'b0);

        // Start glitch, P=16: 4 low cycles
        cfg(6'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        send(16, 16'h0000, 1, 4, -1, 0);
        idle(30);
        chk("glitch_par_err", par_err, 1'b0);
        chk("glitch_stp_err", stp_err, 1'b0);
        chk("glitch_P_DATA_held", P_DATA, 9'h001);

        // Mid-bit single-cycle dip on data bit 2 of 0xFF is outvoted: 9*16+8+2 = 154
        exp_q.push_back('{1'b0, 9'h0FF, cyc + 1 + 154});
        send(16, frame(8, 9'h0FF, 0, 0, 1, 1), 10, 16, 3, 0);
        idle(4);

        // Break, 8N1, P=8: 200 low cycles -> brk_det at 78
        cfg(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{1'b1, 9'h000, cyc + 1 + 78});
        send(8, 16'h0000, 1, 200, -1, 0);
        idle(3);
        chk("brk_stp_err", stp_err, 1'b1);
        chk("brk_par_err", par_err, 1'b0);
        chk("brk_P_DATA_held", P_DATA, 9'h0FF);

        // Framing error, non-zero data: no event, P_DATA unchanged
        send(8, frame(8, 9'h03C, 0, 0, 1, 0), 10, 7, -1, 1);
        idle(4);
        chk("ferr_stp_err", stp_err, 1'b1);
        chk("ferr_P_DATA_held", P_DATA, 9'h0FF);

        // Reset during data bit 4
        send(8, frame(8, 9'h03C, 0, 0, 1, 1), 5, 4, -1, 0);
        RST = 1'b0;
        #1;
        chk("midrst_P_DATA", P_DATA, 9'h000);
        chk("midrst_data_valid", data_valid, 1'b0);
        chk("midrst_par_err", par_err, 1'b0);
        chk("midrst_stp_err", stp_err, 1'b0);
        chk("midrst_brk_det", brk_det, 1'b0);
        RX_IN = 1'b1;
        idle(3);
        RST = 1'b1;
        idle(3);

        // 5N1, Prescale=20 (treated as 16), 0x15: 7 bits -> 6*16+8+2 = 106
        cfg(6'd20, 4'd5, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{1'b0, 9'h015, cyc + 1 + 106});
        send(16, frame(5, 9'h015, 0, 0, 1, 1), 7, 16, -1, 0);
        idle(10);

        chk("events_outstanding", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
